switch_port_tx: RTL and testbench

Per-port egress reader that sits directly downstream of `switch_top`. It drains one output port's pointer FIFO and data FIFO and emits each stored frame as a byte stream (`tx_sof`/`tx_dv`/`tx_eof`/`tx_data`) toward the MAC transmit side. The 2-byte length/portmap header and the 64-byte-granularity padding are stripped. Four instances (ports 0–3) are used, one per `ptr_fifo_*`/`data_fifo_*` group.

---
 rtl/switch_pkg.sv | 17 +
 rtl/switch_port_tx.sv | 151 +++++++++++++++
 tb/tb_switch_port_tx.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_pkg.sv
// Shared constants and FSM encoding for the switch egress port readers.
package switch_pkg;

  localparam int PAD_GRAN = 64;
  localparam int LEN_W    = 12;
  localparam int PTR_W    = 16;
  localparam int CNT_W    = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PTR_LAT,
    ST_WAIT_RDY,
    ST_DATA,
    ST_GAP
  } tx_state_t;

endpackage

// File: rtl/switch_port_tx.sv
// Egress reader for one switch port: pops a pointer, drains the padded frame
// from the data FIFO and emits the payload bytes without header or padding.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | wait for a pointer, issue the pointer pop
// PTR_LAT  | pointer word at the FIFO head; latch len, derive pad_len
// WAIT_RDY | wait for tx_rdy (frames with len <= 2 skip the wait)
// DATA     | pop the data FIFO for pad_len consecutive cycles
// GAP      | inter-frame idle before the next pointer pop
module switch_port_tx
  import switch_pkg::*;
#(
  parameter int IFG = 12
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ptr_fifo_empty,
  input  logic [PTR_W-1:0] ptr_fifo_dout,
  output logic             ptr_fifo_rd,
  output logic             data_fifo_rd,
  input  logic [7:0]       data_fifo_dout,
  input  logic             tx_rdy,
  output logic             tx_sof,
  output logic             tx_eof,
  output logic             tx_dv,
  output logic [7:0]       tx_data,
  output logic             hdr_err,
  output logic             drop
);

  // GAP covers IFG-1 cycles; the IDLE cycle that follows is the last idle one.
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(IFG > 1 ? IFG - 1 : 0);

  tx_state_t        state;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] pad_len;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic             short_q;

  logic [LEN_W-1:0] ptr_len;
  logic [CNT_W-1:0] pad_calc;
  logic             unused_ptr_bits;

  logic             rd_q;
  logic [CNT_W-1:0] k;
  logic [3:0]       hdr_hi;

  assign ptr_len         = ptr_fifo_dout[LEN_W-1:0];
  assign unused_ptr_bits = ^ptr_fifo_dout[PTR_W-1:LEN_W];

  always_comb begin
    pad_calc = ({1'b0, ptr_len} + CNT_W'(PAD_GRAN - 1)) & ~CNT_W'(PAD_GRAN - 1);
    if (ptr_len == '0) pad_calc = CNT_W'(PAD_GRAN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      ptr_fifo_rd  <= 1'b0;
      data_fifo_rd <= 1'b0;
      drop         <= 1'b0;
      len_q        <= '0;
      pad_len      <= '0;
      short_q      <= 1'b0;
      rd_cnt       <= '0;
      gap_cnt      <= '0;
    end else begin
      ptr_fifo_rd <= 1'b0;
      drop        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!ptr_fifo_empty) begin
            ptr_fifo_rd <= 1'b1;
            state       <= ST_PTR_LAT;
          end
        end
        ST_PTR_LAT: begin
          len_q   <= ptr_len;
          pad_len <= pad_calc;
          short_q <= (ptr_len <= LEN_W'(2));
          state   <= ST_WAIT_RDY;
        end
        ST_WAIT_RDY: begin
          if (tx_rdy || short_q) begin
            data_fifo_rd <= 1'b1;
            rd_cnt       <= '0;
            drop         <= short_q;
            state        <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (rd_cnt == pad_len - CNT_W'(1)) begin
            data_fifo_rd <= 1'b0;
            if (IFG > 1) begin
              gap_cnt <= GAP_LOAD;
              state   <= ST_GAP;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            rd_cnt <= rd_cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - CNT_W'(1);
          if (gap_cnt == CNT_W'(1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // k is the index of the byte currently on data_fifo_dout; it restarts
  // whenever the read stream has a hole, which always separates frames.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_q    <= 1'b0;
      k       <= '0;
      hdr_hi  <= '0;
      hdr_err <= 1'b0;
      tx_dv   <= 1'b0;
      tx_sof  <= 1'b0;
      tx_eof  <= 1'b0;
      tx_data <= '0;
    end else begin
      rd_q    <= data_fifo_rd;
      hdr_err <= 1'b0;
      tx_dv   <= 1'b0;
      tx_sof  <= 1'b0;
      tx_eof  <= 1'b0;
      tx_data <= '0;
      if (rd_q) k <= k + CNT_W'(1);
      else      k <= '0;
      if (rd_q) begin
        if (k == CNT_W'(0)) begin
          hdr_hi <= data_fifo_dout[7:4];
        end else if (k == CNT_W'(1)) begin
          hdr_err <= ({hdr_hi, data_fifo_dout} != len_q);
        end else if (k < {1'b0, len_q}) begin
          tx_dv   <= 1'b1;
          tx_data <= data_fifo_dout;
          tx_sof  <= (k == CNT_W'(2));
          tx_eof  <= (k == {1'b0, len_q} - CNT_W'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_port_tx.sv
// Scoreboard bench for switch_port_tx: FIFO models feed stored frames, a
// negedge monitor checks emitted bytes, read bursts and pointer timing.
module tb_switch_port_tx;

  localparam int IFG = 12;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ptr_fifo_empty = 1'b1;
  logic [15:0] ptr_fifo_dout = '0;
  logic        ptr_fifo_rd;
  logic        data_fifo_rd;
  logic [7:0]  data_fifo_dout = '0;
  logic        tx_rdy = 1'b1;
  logic        tx_sof, tx_eof, tx_dv, hdr_err, drop;
  logic [7:0]  tx_data;

  switch_port_tx #(.IFG(IFG)) dut (
    .clk(clk), .rstn(rstn),
    .ptr_fifo_empty(ptr_fifo_empty), .ptr_fifo_dout(ptr_fifo_dout), .ptr_fifo_rd(ptr_fifo_rd),
    .data_fifo_rd(data_fifo_rd), .data_fifo_dout(data_fifo_dout),
    .tx_rdy(tx_rdy), .tx_sof(tx_sof), .tx_eof(tx_eof), .tx_dv(tx_dv), .tx_data(tx_data),
    .hdr_err(hdr_err), .drop(drop)
  );

  always #5 clk = ~clk;

  typedef struct { int len; int pad; bit hdr_bad; } frame_t;
  typedef struct { bit [7:0] data; bit sof; bit eof; } txb_t;

  frame_t      frame_q[$];
  txb_t        exp_q[$];
  logic [7:0]  dq[$];
  logic [15:0] pq[$];

  int vectors = 0, errors = 0, cyc = 0;
  int exp_drops = 0, exp_hdr = 0, seen_drops = 0, seen_hdr = 0;
  int rdy_mode = 1;

  task automatic check(input string name, input bit ok, input longint act, input longint expv);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int pad_of(input int len);
    if (len == 0) return 64;
    return ((len + 63) / 64) * 64;
  endfunction

  task automatic send_frame(input int len, input int hlen, input bit pattern, input logic [3:0] pm);
    int pad;
    logic [11:0] h;
    logic [7:0] b;
    pad = pad_of(len);
    h = hlen[11:0];
    for (int i = 0; i < pad; i++) begin
      if (i == 0)        b = {h[11:8], pm};
      else if (i == 1)   b = h[7:0];
      else if (i < len)  b = pattern ? i[7:0] : 8'($urandom);
      else               b = 8'h00;
      dq.push_back(b);
      if (i >= 2 && i < len) exp_q.push_back('{b, (i == 2), (i == len - 1)});
    end
    frame_q.push_back('{len, pad, (hlen != len)});
    if (hlen != len) exp_hdr++;
    if (len <= 2) exp_drops++;
    pq.push_back({4'($urandom), len[11:0]});
  endtask

  // FWFT pointer FIFO, registered-output data FIFO.
  initial begin
    bit prd, drd;
    forever begin
      @(posedge clk);
      prd = ptr_fifo_rd;
      drd = data_fifo_rd;
      #1;
      if (drd) begin
        check("data_fifo_underrun", dq.size() != 0, dq.size(), 1);
        if (dq.size() != 0) data_fifo_dout = dq.pop_front();
      end
      if (prd && pq.size() != 0) void'(pq.pop_front());
      ptr_fifo_empty = (pq.size() == 0);
      ptr_fifo_dout  = (pq.size() == 0) ? 16'h0 : pq[0];
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       tx_rdy = 1'b0;
        2:       tx_rdy = ($urandom_range(0, 3) != 0);
        default: tx_rdy = 1'b1;
      endcase
    end
  end

  bit     in_rd = 0, have_cur = 0, rdy_at_wait = 0, ptr_avail = 0, prev_rdy = 1, prev_dv = 0;
  int     t_first_rd = -100000, t_ptr = -100000, rd_run = 0, dv_run = 0, sp, lat;
  frame_t cur;
  txb_t   e;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      in_rd = 0; have_cur = 0; rd_run = 0; dv_run = 0; prev_dv = 0;
      t_ptr = -100000; t_first_rd = -100000; ptr_avail = 0;
    end else begin
      if (ptr_fifo_rd) begin
        check("ptr_rd_when_empty", !ptr_fifo_empty, ptr_fifo_empty, 0);
        if (have_cur) begin
          sp = cyc - t_first_rd;
          if (ptr_avail) check("ptr_spacing_exact", sp == cur.pad + IFG, sp, cur.pad + IFG);
          else           check("ptr_spacing_min", sp >= cur.pad + IFG, sp, cur.pad + IFG);
        end
        t_ptr = cyc;
      end
      if (cyc == t_ptr + 1) rdy_at_wait = tx_rdy;

      if (data_fifo_rd && !in_rd) begin
        in_rd = 1; rd_run = 0; t_first_rd = cyc; ptr_avail = 0;
        if (frame_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL rd_without_frame: data_fifo_rd at cycle %0d with no pending frame", cyc);
          have_cur = 0;
        end else begin
          cur = frame_q.pop_front();
          have_cur = 1;
          lat = cyc - t_ptr;
          if (rdy_at_wait || cur.len <= 2) check("rd_latency", lat == 2, lat, 2);
          else check("rd_after_rdy", lat > 2 && prev_rdy, lat, 3);
        end
      end
      if (data_fifo_rd) rd_run++;
      if (!data_fifo_rd && in_rd) begin
        in_rd = 0;
        if (have_cur) check("rd_run_len", rd_run == cur.pad, rd_run, cur.pad);
      end
      if (have_cur && !in_rd && cyc == t_first_rd + cur.pad + IFG - 1) ptr_avail = !ptr_fifo_empty;

      if (drop) begin
        seen_drops++;
        check("drop_timing", have_cur && cur.len <= 2 && cyc == t_first_rd, cyc - t_first_rd, 0);
      end
      if (hdr_err) begin
        seen_hdr++;
        check("hdr_err_timing", have_cur && cur.hdr_bad && cyc == t_first_rd + 3, cyc - t_first_rd, 3);
      end

      if (tx_dv) begin
        dv_run++;
        if (exp_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL tx_unexpected: byte %0h at cycle %0d, none expected", tx_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", tx_data == e.data, tx_data, e.data);
          check("tx_sof", tx_sof == e.sof, tx_sof, e.sof);
          check("tx_eof", tx_eof == e.eof, tx_eof, e.eof);
        end
        if (tx_sof) check("sof_latency", cyc - t_first_rd == 4, cyc - t_first_rd, 4);
      end else begin
        if (tx_sof || tx_eof) begin
          vectors++; errors++;
          $display("FAIL flag_without_dv: sof=%0d eof=%0d at cycle %0d", tx_sof, tx_eof, cyc);
        end
        if (prev_dv && have_cur) check("dv_run_len", dv_run == cur.len - 2, dv_run, cur.len - 2);
        dv_run = 0;
      end
      prev_dv  = tx_dv;
      prev_rdy = tx_rdy;
    end
  end

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && frame_q.size() == 0 && pq.size() == 0 && !in_rd) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("frame_timeout", n < budget, n, budget);
    repeat (IFG + 6) @(posedge clk);
    check("dq_drained", dq.size() == 0, dq.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ptr_fifo_rd"}, ptr_fifo_rd == 1'b0, ptr_fifo_rd, 0);
    check({tag, "_data_fifo_rd"}, data_fifo_rd == 1'b0, data_fifo_rd, 0);
    check({tag, "_tx_sof"}, tx_sof == 1'b0, tx_sof, 0);
    check({tag, "_tx_eof"}, tx_eof == 1'b0, tx_eof, 0);
    check({tag, "_tx_dv"}, tx_dv == 1'b0, tx_dv, 0);
    check({tag, "_tx_data"}, tx_data == 8'h00, tx_data, 0);
    check({tag, "_hdr_err"}, hdr_err == 1'b0, hdr_err, 0);
    check({tag, "_drop"}, drop == 1'b0, drop, 0);
  endtask

  initial begin
    int n, len, hl;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk) rstn = 1'b1;
    n = 0;
    repeat (10) @(negedge clk) if (ptr_fifo_rd) n++;
    check("idle_no_ptr_rd", n == 0, n, 0);

    @(posedge clk) send_frame(126, 126, 1, 4'hF);
    wait_done(2000);
    @(posedge clk) send_frame(129, 129, 1, 4'h3);
    wait_done(2000);
    @(posedge clk) begin send_frame(64, 64, 1, 4'h1); send_frame(64, 64, 1, 4'h2); end
    wait_done(2000);

    rdy_mode = 0;
    @(posedge clk) send_frame(126, 126, 1, 4'h5);
    n = 0;
    while (!ptr_fifo_rd && n < 200) begin @(negedge clk); n++; end
    check("ptr_rd_seen", ptr_fifo_rd == 1'b1, n, 0);
    @(negedge clk);
    n = 0;
    repeat (50) @(negedge clk) if (data_fifo_rd) n++;
    check("no_rd_while_not_rdy", n == 0, n, 0);
    rdy_mode = 1;
    wait_done(2000);

    @(posedge clk) send_frame(128, 126, 1, 4'h7);
    wait_done(2000);
    @(posedge clk) begin send_frame(2, 2, 1, 4'h8); send_frame(126, 126, 1, 4'hF); end
    wait_done(2000);
    @(posedge clk) begin
      send_frame(3, 3, 0, 4'h1); send_frame(0, 0, 0, 4'h2); send_frame(1, 1, 0, 4'h4);
      send_frame(63, 63, 0, 4'h8); send_frame(65, 65, 0, 4'h3);
    end
    wait_done(4000);
    @(posedge clk) send_frame(4095, 4095, 0, 4'hA);
    wait_done(10000);

    rdy_mode = 2;
    for (int f = 0; f < 12; f++) begin
      @(posedge clk);
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : $urandom_range(3, 300);
        hl = len;
        if (len > 2 && $urandom_range(0, 5) == 0) hl = len ^ (1 << $urandom_range(0, 11));
        send_frame(len, hl, 0, 4'($urandom));
      end
      wait_done(4000);
    end

    rdy_mode = 1;
    @(posedge clk) send_frame(300, 300, 0, 4'h6);
    n = 0;
    while (!data_fifo_rd && n < 200) begin @(negedge clk); n++; end
    check("mid_frame_rd_seen", data_fifo_rd == 1'b1, n, 0);
    repeat (20) @(posedge clk);
    #3 rstn = 1'b0;
    #1 check_outputs_zero("async_reset");
    dq.delete(); pq.delete(); exp_q.delete(); frame_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    n = 0;
    repeat (20) @(negedge clk) if (ptr_fifo_rd || data_fifo_rd || tx_dv) n++;
    check("post_reset_idle", n == 0, n, 0);
    @(posedge clk) send_frame(126, 126, 1, 4'hF);
    wait_done(2000);

    check("drop_count", seen_drops == exp_drops, seen_drops, exp_drops);
    check("hdr_err_count", seen_hdr == exp_hdr, seen_hdr, exp_hdr);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
